// File: rtl/opcode_extract_if.sv
// Byte-queue input and decoded-opcode output bundle for opcode_extract.
// master: fetch queue / decode stage side; slave: opcode_extract side.
interface opcode_extract_if #(
  parameter int unsigned LEN_W = 4
) ();
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic [7:0]       opcode;
  logic             opcode_size;
  logic             pfx_opsize;
  logic             pfx_lock;
  logic             pfx_rep;
  logic             pfx_repne;
  logic             seg_ovr_v;
  logic [2:0]       seg_ovr;
  logic [LEN_W-1:0] instr_len;
  logic             err;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output byte_in, byte_valid, out_ready,
    input  byte_ready, opcode, opcode_size, pfx_opsize, pfx_lock, pfx_rep,
           pfx_repne, seg_ovr_v, seg_ovr, instr_len, err, out_valid
  );

  modport slave (
    input  byte_in, byte_valid, out_ready,
    output byte_ready, opcode, opcode_size, pfx_opsize, pfx_lock, pfx_rep,
           pfx_repne, seg_ovr_v, seg_ovr, instr_len, err, out_valid
  );
endinterface

// File: rtl/opcode_extract.sv
// opcode_extract: byte-serial prefix stripper / 0x0F escape resolver feeding
// the microcode control store. Result held under a valid/ready handshake.
// Optional: define OPCODE_EXTRACT_FLUSH_EN to add a synchronous flush input.
module opcode_extract #(
  parameter int unsigned MAX_PREFIX = 4,
  parameter int unsigned LEN_W      = 4
) (
  input logic              clk,
  input logic              reset_n,
`ifdef OPCODE_EXTRACT_FLUSH_EN
  input logic              flush,
`endif
  opcode_extract_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MAX_PREFIX + 1);

  typedef enum logic [1:0] {
    S_PFX = 2'd0,
    S_ESC = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       opcode_q, opcode_d;
  logic             size_q, size_d;
  logic             opsize_q, opsize_d;
  logic             lock_q, lock_d;
  logic             rep_q, rep_d;
  logic             repne_q, repne_d;
  logic             segv_q, segv_d;
  logic [2:0]       seg_q, seg_d;
  logic             err_q, err_d;

  logic             is_pfx;
  logic             seg_hit;
  logic [2:0]       seg_code;
  logic             byte_take;

  // Classify the incoming byte as a legacy prefix and decode segment overrides
  always_comb begin
    is_pfx   = 1'b0;
    seg_hit  = 1'b0;
    seg_code = 3'd0;
    case (bus.byte_in)
      8'h66, 8'hF0, 8'hF2, 8'hF3: is_pfx = 1'b1;
      8'h26: begin is_pfx = 1'b1; seg_hit = 1'b1; seg_code = 3'd0; end
      8'h2E: begin is_pfx = 1'b1; seg_hit = 1'b1; seg_code = 3'd1; end
      8'h36: begin is_pfx = 1'b1; seg_hit = 1'b1; seg_code = 3'd2; end
      8'h3E: begin is_pfx = 1'b1; seg_hit = 1'b1; seg_code = 3'd3; end
      8'h64: begin is_pfx = 1'b1; seg_hit = 1'b1; seg_code = 3'd4; end
      8'h65: begin is_pfx = 1'b1; seg_hit = 1'b1; seg_code = 3'd5; end
      default: ;
    endcase
  end

  assign byte_take = bus.byte_valid && (state_q != S_OUT);

  // Next-state and next-bundle logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    opcode_d = opcode_q;
    size_d   = size_q;
    opsize_d = opsize_q;
    lock_d   = lock_q;
    rep_d    = rep_q;
    repne_d  = repne_q;
    segv_d   = segv_q;
    seg_d    = seg_q;
    err_d    = err_q;

    unique case (state_q)
      S_PFX: begin
        if (byte_take) begin
          len_d = len_q + LEN_W'(1);
          if (is_pfx && (cnt_q < CNT_W'(MAX_PREFIX))) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bus.byte_in == 8'h66) opsize_d = 1'b1;
            if (bus.byte_in == 8'hF0) lock_d   = 1'b1;
            if (bus.byte_in == 8'hF3) rep_d    = 1'b1;
            if (bus.byte_in == 8'hF2) repne_d  = 1'b1;
            if (seg_hit) begin
              segv_d = 1'b1;
              seg_d  = seg_code;
            end
          end else if (is_pfx) begin
            // One prefix too many: hand the offending byte on flagged as an error
            opcode_d = bus.byte_in;
            size_d   = 1'b0;
            err_d    = 1'b1;
            state_d  = S_OUT;
          end else if (bus.byte_in == 8'h0F) begin
            state_d = S_ESC;
          end else begin
            opcode_d = bus.byte_in;
            size_d   = 1'b0;
            state_d  = S_OUT;
          end
        end
      end
      S_ESC: begin
        if (byte_take) begin
          opcode_d = bus.byte_in;
          size_d   = 1'b1;
          len_d    = len_q + LEN_W'(1);
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          cnt_d    = '0;
          len_d    = '0;
          size_d   = 1'b0;
          opsize_d = 1'b0;
          lock_d   = 1'b0;
          rep_d    = 1'b0;
          repne_d  = 1'b0;
          segv_d   = 1'b0;
          seg_d    = 3'd0;
          err_d    = 1'b0;
          state_d  = S_PFX;
        end
      end
      default: state_d = S_PFX;
    endcase

`ifdef OPCODE_EXTRACT_FLUSH_EN
    // Redirect flush wins over byte acceptance and the output handshake
    if (flush) begin
      cnt_d    = '0;
      len_d    = '0;
      size_d   = 1'b0;
      opsize_d = 1'b0;
      lock_d   = 1'b0;
      rep_d    = 1'b0;
      repne_d  = 1'b0;
      segv_d   = 1'b0;
      seg_d    = 3'd0;
      err_d    = 1'b0;
      state_d  = S_PFX;
    end
`endif
  end

  // State and bundle registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_PFX;
      cnt_q    <= '0;
      len_q    <= '0;
      opcode_q <= 8'h00;
      size_q   <= 1'b0;
      opsize_q <= 1'b0;
      lock_q   <= 1'b0;
      rep_q    <= 1'b0;
      repne_q  <= 1'b0;
      segv_q   <= 1'b0;
      seg_q    <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      opcode_q <= opcode_d;
      size_q   <= size_d;
      opsize_q <= opsize_d;
      lock_q   <= lock_d;
      rep_q    <= rep_d;
      repne_q  <= repne_d;
      segv_q   <= segv_d;
      seg_q    <= seg_d;
      err_q    <= err_d;
    end
  end

  assign bus.byte_ready  = (state_q != S_OUT);
  assign bus.out_valid   = (state_q == S_OUT);
  assign bus.opcode      = opcode_q;
  assign bus.opcode_size = size_q;
  assign bus.pfx_opsize  = opsize_q;
  assign bus.pfx_lock    = lock_q;
  assign bus.pfx_rep     = rep_q;
  assign bus.pfx_repne   = repne_q;
  assign bus.seg_ovr_v   = segv_q;
  assign bus.seg_ovr     = seg_q;
  assign bus.instr_len   = len_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_opcode_extract.sv
// Directed bench for opcode_extract: vector table plus multi-cycle sequences.
module tb_opcode_extract;

  logic clk;
  logic reset_n;
`ifdef OPCODE_EXTRACT_FLUSH_EN
  logic flush;
`endif

  opcode_extract_if #(.LEN_W(4)) bus ();

  opcode_extract #(.MAX_PREFIX(4), .LEN_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef OPCODE_EXTRACT_FLUSH_EN
    .flush   (flush),
`endif
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // bytes: first byte in [7:0]; pf = {opsize, lock, rep, repne}
  typedef struct {
    logic [47:0] bytes;
    int          n;
    logic [7:0]  op;
    logic        sz;
    logic [3:0]  pf;
    logic        segv;
    logic [2:0]  seg;
    logic [3:0]  len;
    logic        err;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    step();
    bus.byte_valid = 1'b0;
  endtask

  task automatic chk_bundle(input string nm, input logic [7:0] op, input logic sz,
                            input logic [3:0] pf, input logic segv, input logic [2:0] seg,
                            input logic [3:0] len, input logic e);
    chk({nm, ".opcode"}, 32'(bus.opcode), 32'(op));
    chk({nm, ".size"},   32'(bus.opcode_size), 32'(sz));
    chk({nm, ".pfx"},    32'({bus.pfx_opsize, bus.pfx_lock, bus.pfx_rep, bus.pfx_repne}), 32'(pf));
    chk({nm, ".segv"},   32'(bus.seg_ovr_v), 32'(segv));
    chk({nm, ".seg"},    32'(bus.seg_ovr), 32'(seg));
    chk({nm, ".len"},    32'(bus.instr_len), 32'(len));
    chk({nm, ".err"},    32'(bus.err), 32'(e));
  endtask

  task automatic chk_idle(input string nm, input logic [7:0] op);
    chk({nm, ".valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, ".ready"}, 32'(bus.byte_ready), 32'd1);
    chk_bundle(nm, op, 1'b0, 4'b0000, 1'b0, 3'd0, 4'd0, 1'b0);
  endtask

  task automatic release_bundle(input string nm, input logic [7:0] op);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk_idle({nm, ".rel"}, op);
  endtask

  initial begin
    vecs[0] = '{48'h0000_0000_0089, 1, 8'h89, 1'b0, 4'b0000, 1'b0, 3'd0, 4'd1, 1'b0};
    vecs[1] = '{48'h00AF_0F2E_F366, 5, 8'hAF, 1'b1, 4'b1010, 1'b1, 3'd1, 4'd5, 1'b0};
    vecs[2] = '{48'h0000_C365_6426, 4, 8'hC3, 1'b0, 4'b0000, 1'b1, 3'd5, 4'd4, 1'b0};
    vecs[3] = '{48'h0066_6666_6666, 5, 8'h66, 1'b0, 4'b1000, 1'b0, 3'd0, 4'd5, 1'b1};
    vecs[4] = '{48'h0066_0FF3_F2F0, 5, 8'h66, 1'b1, 4'b0111, 1'b0, 3'd0, 4'd5, 1'b0};
    vecs[5] = '{48'h0000_0000_0F0F, 2, 8'h0F, 1'b1, 4'b0000, 1'b0, 3'd0, 4'd2, 1'b0};
    vecs[6] = '{48'h0000_0090_363E, 3, 8'h90, 1'b0, 4'b0000, 1'b1, 3'd2, 4'd3, 1'b0};
    vecs[7] = '{48'h003E_66F2_26F0, 5, 8'h3E, 1'b0, 4'b1101, 1'b1, 3'd0, 4'd5, 1'b1};
    vecs[8] = '{48'hC80F_F3F2_F066, 6, 8'hC8, 1'b1, 4'b1111, 1'b0, 3'd0, 4'd6, 1'b0};

    reset_n        = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.out_ready  = 1'b0;
`ifdef OPCODE_EXTRACT_FLUSH_EN
    flush          = 1'b0;
`endif
    step();
    step();
    chk_idle("reset", 8'h00);
    reset_n = 1'b1;
    step();
    chk_idle("post_reset", 8'h00);

    // Table-driven instructions
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        if (i == vecs[v].n - 1) chk($sformatf("v%0d.pre_valid", v), 32'(bus.out_valid), 32'd0);
        send(vecs[v].bytes[8*i +: 8]);
      end
      chk($sformatf("v%0d.valid", v), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d.ready", v), 32'(bus.byte_ready), 32'd0);
      chk_bundle($sformatf("v%0d", v), vecs[v].op, vecs[v].sz, vecs[v].pf,
                 vecs[v].segv, vecs[v].seg, vecs[v].len, vecs[v].err);
      release_bundle($sformatf("v%0d", v), vecs[v].op);
    end

    // Back-pressure: bundle held while out_ready low, byte waits
    send(8'h90);
    bus.byte_in    = 8'h55;
    bus.byte_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d.ready", c), 32'(bus.byte_ready), 32'd0);
      chk($sformatf("stall%0d.valid", c), 32'(bus.out_valid), 32'd1);
      chk_bundle($sformatf("stall%0d", c), 8'h90, 1'b0, 4'b0000, 1'b0, 3'd0, 4'd1, 1'b0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk_idle("stall.rel", 8'h90);
    step();
    bus.byte_valid = 1'b0;
    chk("stall.next_valid", 32'(bus.out_valid), 32'd1);
    chk_bundle("stall.next", 8'h55, 1'b0, 4'b0000, 1'b0, 3'd0, 4'd1, 1'b0);
    release_bundle("stall.next", 8'h55);

    // out_ready while idle is ignored; partial prefix/escape state holds
    bus.out_ready = 1'b1;
    step();
    step();
    bus.out_ready = 1'b0;
    chk_idle("idle_ready", 8'h55);
    send(8'h66);
    bus.out_ready = 1'b1;
    step();
    step();
    step();
    bus.out_ready = 1'b0;
    chk("hold_pfx.valid", 32'(bus.out_valid), 32'd0);
    chk_bundle("hold_pfx", 8'h55, 1'b0, 4'b1000, 1'b0, 3'd0, 4'd1, 1'b0);
    send(8'h0F);
    step();
    step();
    step();
    chk("hold_esc.ready", 32'(bus.byte_ready), 32'd1);
    chk("hold_esc.valid", 32'(bus.out_valid), 32'd0);
    chk("hold_esc.len", 32'(bus.instr_len), 32'd2);
    send(8'h10);
    chk("hold.valid", 32'(bus.out_valid), 32'd1);
    chk_bundle("hold", 8'h10, 1'b1, 4'b1000, 1'b0, 3'd0, 4'd3, 1'b0);
    release_bundle("hold", 8'h10);

    // Asynchronous reset between escape and opcode discards the escape
    send(8'h2E);
    send(8'h0F);
    reset_n = 1'b0;
    #1;
    chk_idle("rst_mid", 8'h00);
    #2;
    reset_n = 1'b1;
    step();
    send(8'hB6);
    chk("rst_mid.after_valid", 32'(bus.out_valid), 32'd1);
    chk_bundle("rst_mid.after", 8'hB6, 1'b0, 4'b0000, 1'b0, 3'd0, 4'd1, 1'b0);
    release_bundle("rst_mid.after", 8'hB6);

`ifdef OPCODE_EXTRACT_FLUSH_EN
    // Flush in S_ESC drops the presented byte and clears partial state
    send(8'h66);
    send(8'h0F);
    flush          = 1'b1;
    bus.byte_in    = 8'hB6;
    bus.byte_valid = 1'b1;
    step();
    flush          = 1'b0;
    bus.byte_valid = 1'b0;
    chk_idle("flush_esc", 8'hB6);
    send(8'hB6);
    chk("flush_esc.after_valid", 32'(bus.out_valid), 32'd1);
    chk_bundle("flush_esc.after", 8'hB6, 1'b0, 4'b0000, 1'b0, 3'd0, 4'd1, 1'b0);
    // Flush in S_OUT beats the handshake
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    step();
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    chk_idle("flush_out", 8'hB6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
